// File: rtl/rv32c_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : rv32c_fetch_aligner
// Description : RV32C fetch aligner. Fetches aligned 32-bit words into a
//               4-halfword buffer and presents one 16/32-bit instruction per
//               handshake. Optional feature macro: RV32C_ALIGNER_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32c_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter int          BUF_HW   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_is_c
`ifdef RV32C_ALIGNER_FAULT_EN
    ,
    output logic        fault_misaligned
`endif
);

    logic [15:0] buf_q [0:BUF_HW-1];
    logic [15:0] buf_d [0:BUF_HW-1];
    logic [15:0] w_sh  [0:BUF_HW-1];
    logic [2:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_first_q, drop_first_d;
    logic        squash_q, squash_d;
    logic        pending_q, pending_d;

    logic        w_fault;
    logic        w_hw0_c;
    logic        w_accept;
    logic        w_complete;
    logic        w_issue;
    logic [2:0]  w_pop;
    logic [2:0]  w_app;
    logic [2:0]  w_base;
    logic [15:0] w_app0;
    logic [15:0] w_app1;

    assign w_hw0_c    = (buf_q[0][1:0] != 2'b11);
    assign out_valid  = ((count_q >= 3'd1 && w_hw0_c) || count_q >= 3'd2) && !w_fault;
    assign out_is_c   = (count_q != 3'd0) && w_hw0_c;
    assign out_inst   = !out_valid ? 32'h0 :
                        w_hw0_c    ? {16'h0, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign out_pc     = head_pc_q;
    assign imem_ren   = pending_q;
    assign imem_addr  = addr_q;

    assign w_accept   = out_valid && out_ready;
    assign w_complete = pending_q && !imem_busy;
    assign w_issue    = !pending_q && !halt && !redirect_en && !w_fault &&
                        (count_q <= 3'(BUF_HW - 2));
    assign w_pop      = !w_accept ? 3'd0 : (w_hw0_c ? 3'd1 : 3'd2);
    assign w_app      = (!w_complete || squash_q) ? 3'd0 :
                        (drop_first_q ? 3'd1 : 3'd2);
    assign w_app0     = drop_first_q ? imem_rdata[31:16] : imem_rdata[15:0];
    assign w_app1     = imem_rdata[31:16];
    assign w_base     = count_q - w_pop;

    // Pop first, then append at the post-pop tail.
    always_comb begin
        w_sh[0] = (w_pop == 3'd2) ? buf_q[2] : (w_pop == 3'd1) ? buf_q[1] : buf_q[0];
        w_sh[1] = (w_pop == 3'd2) ? buf_q[3] : (w_pop == 3'd1) ? buf_q[2] : buf_q[1];
        w_sh[2] = (w_pop == 3'd2) ? 16'h0    : (w_pop == 3'd1) ? buf_q[3] : buf_q[2];
        w_sh[3] = (w_pop != 3'd0) ? 16'h0    : buf_q[3];
        for (int i = 0; i < BUF_HW; i++) begin
            buf_d[i] = w_sh[i];
            if (w_app != 3'd0 && w_base == 3'(i)) begin
                buf_d[i] = w_app0;
            end
            if (w_app == 3'd2 && (w_base + 3'd1) == 3'(i)) begin
                buf_d[i] = w_app1;
            end
        end
    end

    always_comb begin
        count_d      = count_q - w_pop + w_app;
        head_pc_d    = head_pc_q + {28'h0, w_pop, 1'b0};
        fetch_pc_d   = fetch_pc_q;
        addr_d       = addr_q;
        drop_first_d = drop_first_q;
        squash_d     = squash_q;
        pending_d    = pending_q;

        if (w_complete) begin
            pending_d = 1'b0;
            if (squash_q) begin
                // fetch_pc already points at the redirect target
                squash_d = 1'b0;
            end else begin
                fetch_pc_d   = fetch_pc_q + 32'd4;
                drop_first_d = 1'b0;
            end
        end

        if (w_issue) begin
            pending_d = 1'b1;
            addr_d    = fetch_pc_q;
        end

        if (redirect_en) begin
            count_d      = 3'd0;
            head_pc_d    = {redirect_pc[31:1], 1'b0};
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            drop_first_d = redirect_pc[1];
            if (pending_q && imem_busy) begin
                squash_d  = 1'b1;
                pending_d = 1'b1;
            end else begin
                squash_d  = 1'b0;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= 16'h0;
            end
            count_q      <= 3'd0;
            head_pc_q    <= RESET_PC;
            fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
            addr_q       <= {RESET_PC[31:2], 2'b00};
            drop_first_q <= RESET_PC[1];
            squash_q     <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= buf_d[i];
            end
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            drop_first_q <= drop_first_d;
            squash_q     <= squash_d;
            pending_q    <= pending_d;
        end
    end

`ifdef RV32C_ALIGNER_FAULT_EN
    logic fault_q, fault_d;

    // An odd redirect target latches the fault until the next redirect.
    always_comb begin
        fault_d = fault_q;
        if (redirect_en) begin
            fault_d = redirect_pc[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign w_fault          = fault_q;
    assign fault_misaligned = fault_q;
`else
    logic w_unused_pc0;
    assign w_unused_pc0 = redirect_pc[0];
    assign w_fault      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32c_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32c_fetch_aligner
// Description : Directed bench with an instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32c_fetch_aligner;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0200;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_c;
`ifdef RV32C_ALIGNER_FAULT_EN
    logic        fault_misaligned;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 CLK = ~CLK;

    rv32c_fetch_aligner #(.RESET_PC(C_RESET_PC), .BUF_HW(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .imem_busy   (imem_busy),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_is_c    (out_is_c)
`ifdef RV32C_ALIGNER_FAULT_EN
        ,
        .fault_misaligned (fault_misaligned)
`endif
    );

    // Unwritten memory holds distinct compressed halfwords per address.
    function automatic logic [15:0] hw_default(input logic [31:0] a);
        return {a[14:1], 2'b01};
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return {hw_default(w + 32'd2), hw_default(w)};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    always begin
        @(negedge CLK);
        #2;
        imem_rdata = word_at(imem_addr);
    end

    // Reference model: walk the instruction stream from the expected PC.
    logic [31:0] exp_pc = C_RESET_PC;
    logic        prev_redirect = 1'b0;
    logic        prev_ren = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_halt = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_addr = 32'h0;

    always begin
        logic [15:0] h0;
        logic        c;
        logic [31:0] inst;
        @(negedge CLK);
        #4;
        if (RST) begin
            exp_pc = C_RESET_PC;
        end else begin
            if (prev_redirect) check("mon_valid_after_redirect", {31'h0, out_valid}, 32'h0);
            if (imem_ren && !prev_ren && !prev_rst) begin
                check("mon_issue_while_halt", {31'h0, prev_halt}, 32'h0);
                check("mon_issue_on_redirect", {31'h0, prev_redirect}, 32'h0);
            end
            if (imem_ren) check("mon_addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
            if (prev_ren && prev_busy && !prev_rst) begin
                check("mon_req_held_ren", {31'h0, imem_ren}, 32'h1);
                check("mon_req_held_addr", imem_addr, prev_addr);
            end
            h0   = hw_at(exp_pc);
            c    = (h0[1:0] != 2'b11);
            inst = c ? {16'h0, h0} : {hw_at(exp_pc + 32'd2), h0};
            if (out_valid) begin
                check("mon_pc", out_pc, exp_pc);
                check("mon_inst", out_inst, inst);
                check("mon_is_c", {31'h0, out_is_c}, {31'h0, c});
            end
            if (redirect_en) exp_pc = {redirect_pc[31:1], 1'b0};
            else if (out_valid && out_ready) exp_pc = exp_pc + (c ? 32'd2 : 32'd4);
        end
        prev_redirect = redirect_en;
        prev_ren      = imem_ren;
        prev_busy     = imem_busy;
        prev_halt     = halt;
        prev_rst      = RST;
        prev_addr     = imem_addr;
    end

    task automatic cyc();
        @(negedge CLK);
        #3;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            cyc();
            n++;
        end
        if (!out_valid) check({name, "_valid_timeout"}, {31'h0, out_valid}, 32'h1);
    endtask

    task automatic wait_ren(input string name);
        int n;
        n = 0;
        while (!imem_ren && n < 60) begin
            cyc();
            n++;
        end
        if (!imem_ren) check({name, "_ren_timeout"}, {31'h0, imem_ren}, 32'h1);
    endtask

    task automatic expect_next(input logic [31:0] pc, input logic [31:0] inst,
                               input logic isc, input string name);
        wait_valid(name);
        check({name, "_pc"}, out_pc, pc);
        check({name, "_inst"}, out_inst, inst);
        check({name, "_is_c"}, {31'h0, out_is_c}, {31'h0, isc});
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_en = 1'b1;
        redirect_pc = pc;
        cyc();
        redirect_en = 1'b0;
    endtask

    initial begin
        mem[32'h200] = 32'h0001_0001;
        repeat (3) cyc();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_imem_ren", {31'h0, imem_ren}, 32'h0);
        check("rst_out_pc", out_pc, 32'h200);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_is_c", {31'h0, out_is_c}, 32'h0);

        // Zero-wait fetch of two C.NOPs
        RST = 1'b0;
        cyc();
        check("t1_first_ren", {31'h0, imem_ren}, 32'h1);
        check("t1_first_addr", imem_addr, 32'h200);
        expect_next(32'h200, 32'h0001, 1'b1, "t1_nop0");
        expect_next(32'h202, 32'h0001, 1'b1, "t1_nop1");

        // Straddling 32-bit instruction
        RST = 1'b1;
        imem_busy = 1'b1;
        mem[32'h200] = 32'h0013_4501;
        mem[32'h204] = 32'h0001_0000;
        repeat (2) cyc();
        RST = 1'b0;
        wait_ren("t2_req0");
        check("t2_addr0", imem_addr, 32'h200);
        imem_busy = 1'b0;
        cyc();
        imem_busy = 1'b1;
        wait_ren("t2_req1");
        check("t2_addr1", imem_addr, 32'h204);
        expect_next(32'h200, 32'h4501, 1'b1, "t2_cli");
        for (int i = 0; i < 3; i++) begin
            check("t2_straddle_wait", {31'h0, out_valid}, 32'h0);
            cyc();
        end
        imem_busy = 1'b0;
        expect_next(32'h202, 32'h0000_0013, 1'b0, "t2_addi");
        expect_next(32'h206, 32'h0001, 1'b1, "t2_nop");

        // Redirect to upper halfword of a word
        pulse_redirect(32'h302);
        wait_ren("t3_req");
        check("t3_addr", imem_addr, 32'h300);
        expect_next(32'h302, 32'h0605, 1'b1, "t3_first");

        // Redirect while the bus is stalled
        halt = 1'b1;
        repeat (3) cyc();
        imem_busy = 1'b1;
        pulse_redirect(32'h500);
        halt = 1'b0;
        wait_ren("t4_req_old");
        check("t4_addr_old", imem_addr, 32'h500);
        pulse_redirect(32'h400);
        for (int i = 0; i < 3; i++) begin
            check("t4_held_ren", {31'h0, imem_ren}, 32'h1);
            check("t4_held_addr", imem_addr, 32'h500);
            check("t4_no_valid", {31'h0, out_valid}, 32'h0);
            cyc();
        end
        imem_busy = 1'b0;
        cyc();
        check("t4_no_stale", {31'h0, out_valid}, 32'h0);
        wait_ren("t4_req_new");
        check("t4_addr_new", imem_addr, 32'h400);
        expect_next(32'h400, 32'h0801, 1'b1, "t4_first");

        // Backpressure fills the buffer, then drain under halt
        pulse_redirect(32'h600);
        repeat (10) cyc();
        check("t5_sat_ren", {31'h0, imem_ren}, 32'h0);
        check("t5_sat_valid", {31'h0, out_valid}, 32'h1);
        halt = 1'b1;
        expect_next(32'h600, 32'h0C01, 1'b1, "t5_hw0");
        expect_next(32'h602, 32'h0C05, 1'b1, "t5_hw1");
        expect_next(32'h604, 32'h0C09, 1'b1, "t5_hw2");
        expect_next(32'h606, 32'h0C0D, 1'b1, "t5_hw3");
        for (int i = 0; i < 3; i++) begin
            check("t5_halt_empty_valid", {31'h0, out_valid}, 32'h0);
            check("t5_halt_no_ren", {31'h0, imem_ren}, 32'h0);
            cyc();
        end
        halt = 1'b0;
        expect_next(32'h608, 32'h0C11, 1'b1, "t5_resume");

`ifdef RV32C_ALIGNER_FAULT_EN
        pulse_redirect(32'h301);
        repeat (2) cyc();
        for (int i = 0; i < 5; i++) begin
            check("t6_fault_flag", {31'h0, fault_misaligned}, 32'h1);
            check("t6_fault_valid", {31'h0, out_valid}, 32'h0);
            check("t6_fault_ren", {31'h0, imem_ren}, 32'h0);
            cyc();
        end
        pulse_redirect(32'h400);
        check("t6_fault_clear", {31'h0, fault_misaligned}, 32'h0);
        expect_next(32'h400, 32'h0801, 1'b1, "t6_recover");
`endif

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
